// File: rtl/sine_pkg.sv
// Shared constants and quarter-wave table for the sine DAC generator.
// Table entry i holds round(511.5 + 511.5*sin(2*pi*(i+0.5)/512)).
package sine_pkg;

  localparam int DAC_BITS   = 10;
  localparam int PHASE_BITS = 9;
  localparam int QTR_BITS   = PHASE_BITS - 2;
  localparam int QTR_DEPTH  = 2 ** QTR_BITS;

  localparam logic [DAC_BITS-1:0] MIDSCALE = 10'd512;
  localparam logic [DAC_BITS-1:0] DAC_MAX  = 10'd1023;

  localparam logic [DAC_BITS-1:0] QTR_ROM [QTR_DEPTH] = '{
    10'd515, 10'd521, 10'd527, 10'd533,
    10'd540, 10'd546, 10'd552, 10'd559,
    10'd565, 10'd571, 10'd577, 10'd583,
    10'd590, 10'd596, 10'd602, 10'd608,
    10'd614, 10'd621, 10'd627, 10'd633,
    10'd639, 10'd645, 10'd651, 10'd657,
    10'd663, 10'd669, 10'd675, 10'd681,
    10'd687, 10'd693, 10'd698, 10'd704,
    10'd710, 10'd716, 10'd722, 10'd727,
    10'd733, 10'd739, 10'd744, 10'd750,
    10'd755, 10'd761, 10'd766, 10'd772,
    10'd777, 10'd782, 10'd788, 10'd793,
    10'd798, 10'd803, 10'd809, 10'd814,
    10'd819, 10'd824, 10'd829, 10'd834,
    10'd838, 10'd843, 10'd848, 10'd853,
    10'd857, 10'd862, 10'd866, 10'd871,
    10'd875, 10'd880, 10'd884, 10'd888,
    10'd893, 10'd897, 10'd901, 10'd905,
    10'd909, 10'd913, 10'd917, 10'd920,
    10'd924, 10'd928, 10'd931, 10'd935,
    10'd939, 10'd942, 10'd945, 10'd949,
    10'd952, 10'd955, 10'd958, 10'd961,
    10'd964, 10'd967, 10'd970, 10'd973,
    10'd975, 10'd978, 10'd980, 10'd983,
    10'd985, 10'd988, 10'd990, 10'd992,
    10'd994, 10'd996, 10'd998, 10'd1000,
    10'd1002, 10'd1004, 10'd1005, 10'd1007,
    10'd1008, 10'd1010, 10'd1011, 10'd1013,
    10'd1014, 10'd1015, 10'd1016, 10'd1017,
    10'd1018, 10'd1019, 10'd1020, 10'd1020,
    10'd1021, 10'd1021, 10'd1022, 10'd1022,
    10'd1023, 10'd1023, 10'd1023, 10'd1023
  };

endpackage

// File: rtl/sine_qtr_rom.sv
// Quarter-wave sine lookup: 7-bit address to 10-bit unsigned sample.
// Purely combinational; maps to LUTs or a ROM block.
module sine_qtr_rom
  import sine_pkg::*;
(
  input  logic [QTR_BITS-1:0] addr_i,
  output logic [DAC_BITS-1:0] data_o
);

  assign data_o = QTR_ROM[addr_i];

endmodule

// File: rtl/sine_dac_gen.sv
// Free-running 512-sample sine generator driving a 10-bit ladder DAC.
// Quarter-wave table is mirrored and inverted per quadrant; pins are flopped.
module sine_dac_gen
  import sine_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic _9b,
  output logic _6a,
  output logic _4a,
  output logic _2a,
  output logic _0a,
  output logic _5a,
  output logic _3b,
  output logic _49a,
  output logic _45a,
  output logic _48b
);

  logic [PHASE_BITS-1:0] phase_q;
  logic [PHASE_BITS-1:0] phase_d;
  logic [DAC_BITS-1:0]   dac_q;
  logic [DAC_BITS-1:0]   dac_d;
  logic [1:0]            quad;
  logic [QTR_BITS-1:0]   k;
  logic [QTR_BITS-1:0]   rom_addr;
  logic [DAC_BITS-1:0]   rom_data;

  assign quad = phase_q[PHASE_BITS-1 -: 2];
  assign k    = phase_q[QTR_BITS-1:0];

  // Odd quadrants walk the table backwards: 127-k == ~k.
  assign rom_addr = quad[0] ? ~k : k;

  sine_qtr_rom u_rom (
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  assign dac_d   = quad[1] ? (DAC_MAX - rom_data) : rom_data;
  assign phase_d = phase_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      dac_q   <= MIDSCALE;
    end else begin
      phase_q <= phase_d;
      dac_q   <= dac_d;
    end
  end

  assign {_9b, _6a, _4a, _2a, _0a,
          _5a, _3b, _49a, _45a, _48b} = dac_q;

endmodule

// File: tb/tb_sine_dac_gen.sv
// Directed bench for sine_dac_gen: reset, release, peaks,
// half-period symmetry, wrap and mid-run reset.
module tb_sine_dac_gen;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic clk_run = 1'b0;

  logic _9b, _6a, _4a, _2a, _0a;
  logic _5a, _3b, _49a, _45a, _48b;
  logic [9:0] pins;

  int tests = 0;
  int fails = 0;

  logic [9:0] samp [0:513];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  sine_dac_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    ._9b   (_9b),
    ._6a   (_6a),
    ._4a   (_4a),
    ._2a   (_2a),
    ._0a   (_0a),
    ._5a   (_5a),
    ._3b   (_3b),
    ._49a  (_49a),
    ._45a  (_45a),
    ._48b  (_48b)
  );

  assign pins = {_9b, _6a, _4a, _2a, _0a,
                 _5a, _3b, _49a, _45a, _48b};

  task automatic test_reset;
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    tests++;
    if (pins !== 10'd512) begin
      fails++;
      $display("FAIL reset_noclk: got %0d want 512", pins);
    end
    tests++;
    if ({_9b, _6a, _48b} !== 3'b100) begin
      fails++;
      $display("FAIL reset_pins: got %b want 100", {_9b, _6a, _48b});
    end
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (pins !== 10'd512) begin
      fails++;
      $display("FAIL reset_held: got %0d want 512", pins);
    end
  endtask

  task automatic test_release;
    rst_n = 1'b1;
    @(negedge clk);
    samp[0] = pins;
    tests++;
    if (pins !== 10'd515) begin
      fails++;
      $display("FAIL release_first: got %0d want 515", pins);
    end
    tests++;
    if ({_9b, _45a, _48b} !== 3'b111 || {_6a, _4a, _2a, _0a, _5a, _3b, _49a} !== 7'd0) begin
      fails++;
      $display("FAIL release_pins: got %b want 1000000011", pins);
    end
    @(negedge clk);
    samp[1] = pins;
    tests++;
    if (pins !== 10'd521) begin
      fails++;
      $display("FAIL release_second: got %0d want 521", pins);
    end
  endtask

  task automatic test_period;
    for (int p = 2; p < 514; p++) begin
      @(negedge clk);
      samp[p] = pins;
    end
  endtask

  task automatic test_peaks;
    int idx [11];
    logic [9:0] exp_v [11];
    idx   = '{127, 128, 383, 384, 64, 192, 320, 448, 255, 256, 257};
    exp_v = '{10'd1023, 10'd1023, 10'd0, 10'd0, 10'd875, 10'd871,
              10'd148, 10'd152, 10'd515, 10'd508, 10'd502};
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (samp[idx[i]] !== exp_v[i]) begin
        fails++;
        $display("FAIL peak_phase_%0d: got %0d want %0d",
                 idx[i], samp[idx[i]], exp_v[i]);
      end
    end
  endtask

  task automatic test_symmetry;
    for (int p = 0; p < 256; p++) begin
      tests++;
      if ((11'(samp[p]) + 11'(samp[p+256])) !== 11'd1023) begin
        fails++;
        $display("FAIL symmetry_%0d: got %0d+%0d want sum 1023",
                 p, samp[p], samp[p+256]);
      end
    end
  endtask

  task automatic test_wrap;
    tests++;
    if (samp[511] !== 10'd508) begin
      fails++;
      $display("FAIL wrap_511: got %0d want 508", samp[511]);
    end
    tests++;
    if (samp[512] !== 10'd515) begin
      fails++;
      $display("FAIL wrap_0: got %0d want 515", samp[512]);
    end
    tests++;
    if (samp[513] !== 10'd521) begin
      fails++;
      $display("FAIL wrap_1: got %0d want 521", samp[513]);
    end
  endtask

  task automatic test_midrun_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    tests++;
    if (pins !== 10'd838) begin
      fails++;
      $display("FAIL midrun_phase199: got %0d want 838", pins);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (pins !== 10'd512) begin
      fails++;
      $display("FAIL midrun_async: got %0d want 512", pins);
    end
    @(negedge clk);
    tests++;
    if (pins !== 10'd512) begin
      fails++;
      $display("FAIL midrun_held: got %0d want 512", pins);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (pins !== 10'd515) begin
      fails++;
      $display("FAIL midrun_restart0: got %0d want 515", pins);
    end
    @(negedge clk);
    tests++;
    if (pins !== 10'd521) begin
      fails++;
      $display("FAIL midrun_restart1: got %0d want 521", pins);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_period();
    test_peaks();
    test_symmetry();
    test_wrap();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
